// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tristate bus selector: FSM state encodings and a
// constant-evaluable clog2 used to size the select port.
package tri_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GAP   = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tri_drv.sv
// W-bit tristate driver: one bufif1 per bit, all gated by a single enable.
module tri_drv #(
  parameter int W = 1
) (
  input  logic [W-1:0] in,
  input  logic         ctrl,
  output wire  [W-1:0] z
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    bufif1 u_buf (z[b], in[b], ctrl);
  end

endmodule

// File: rtl/tri_bus_sel.sv
// N:1 selector onto a shared tristate bus. Registered one-hot enables with a
// break-before-make gap, manual request or round-robin scan, and a bus capture.
module tri_bus_sel
  import tri_bus_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int GAP   = 1,
  parameter  int DWELL = 4,
  localparam int SW    = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic           req_vld,
  input  logic [SW-1:0]  req_sel,
  output logic           req_rdy,
  input  logic [N*W-1:0] i,
  output logic [N-1:0]   en,
  output wire  [W-1:0]   y,
  output logic [SW-1:0]  cur_sel,
  output logic [W-1:0]   y_q,
  output logic           y_vld,
  output logic           err
);

  logic [1:0]    state, state_nxt;
  logic [1:0]    gcnt, gcnt_nxt;
  logic [7:0]    dcnt, dcnt_nxt;
  logic          scan_q, scan_nxt;
  logic [SW-1:0] sel_nxt, next_sel;
  logic [N-1:0]  en_nxt;
  logic          err_nxt, cap, go, acc, legal;
  logic [W-1:0]  bus_val;

  function automatic logic [N-1:0] onehot(input logic [SW-1:0] s);
    logic [N-1:0] r;
    r = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_drv
    tri_drv #(.W(W)) u_drv (
      .in   (i[k*W +: W]),
      .ctrl (en[k]),
      .z    (y)
    );
  end

  // Same value the bus carries whenever the owning driver is enabled.
  assign bus_val  = i[cur_sel*W +: W];
  assign legal    = {1'b0, req_sel} < (SW+1)'(N);
  assign next_sel = (cur_sel == SW'(N-1)) ? '0 : cur_sel + 1'b1;
  assign req_rdy  = rst_n & ~mode &
                    ((state == ST_IDLE) | ((state == ST_DRIVE) & ~scan_q));
  assign acc      = req_vld & req_rdy;

  always_comb begin
    state_nxt = state;
    sel_nxt   = cur_sel;
    en_nxt    = en;
    gcnt_nxt  = gcnt;
    dcnt_nxt  = dcnt;
    scan_nxt  = scan_q;
    err_nxt   = 1'b0;
    cap       = 1'b0;
    go        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode) begin
          go       = 1'b1;
          sel_nxt  = '0;
          scan_nxt = 1'b1;
        end else if (acc) begin
          if (legal) begin
            go       = 1'b1;
            sel_nxt  = req_sel;
            scan_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gcnt == 2'(GAP-1)) begin
          state_nxt = ST_DRIVE;
          en_nxt    = onehot(cur_sel);
        end else begin
          gcnt_nxt = gcnt + 2'd1;
        end
      end
      ST_DRIVE: begin
        cap = 1'b1;
        if (scan_q) begin
          // Mode is only re-sampled once the dwell on this channel is complete.
          if (dcnt == 8'(DWELL-1)) begin
            dcnt_nxt = '0;
            if (mode) begin
              go      = 1'b1;
              sel_nxt = next_sel;
            end else begin
              scan_nxt = 1'b0;
            end
          end else begin
            dcnt_nxt = dcnt + 8'd1;
          end
        end else if (mode) begin
          scan_nxt = 1'b1;
          dcnt_nxt = '0;
        end else if (acc) begin
          if (!legal) begin
            err_nxt = 1'b1;
          end else if (req_sel != cur_sel) begin
            go      = 1'b1;
            sel_nxt = req_sel;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Channel change: with no gap the enable moves in a single registered step.
    if (go) begin
      cap      = 1'b0;
      gcnt_nxt = '0;
      dcnt_nxt = '0;
      if (GAP == 0) begin
        state_nxt = ST_DRIVE;
        en_nxt    = onehot(sel_nxt);
      end else begin
        state_nxt = ST_GAP;
        en_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      en      <= '0;
      cur_sel <= '0;
      gcnt    <= '0;
      dcnt    <= '0;
      scan_q  <= 1'b0;
      err     <= 1'b0;
      y_q     <= '0;
      y_vld   <= 1'b0;
    end else begin
      state   <= state_nxt;
      en      <= en_nxt;
      cur_sel <= sel_nxt;
      gcnt    <= gcnt_nxt;
      dcnt    <= dcnt_nxt;
      scan_q  <= scan_nxt;
      err     <= err_nxt;
      y_vld   <= cap;
      if (cap) y_q <= bus_val;
    end
  end

endmodule

// File: tb/tb_tri_bus_sel.sv
// Directed bench: table of per-cycle vectors on an N=4/GAP=1 instance, plus a
// hand sequence on an N=3/GAP=0 instance for direct switching and illegal selects.
module tb_tri_bus_sel;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Instance A: N=4 W=1 GAP=1 DWELL=2
  logic       rst_a, mode_a, vld_a, rdy_a, err_a, yvld_a, yq_a;
  logic [1:0] sel_a, csel_a;
  logic [3:0] i_a, en_a;
  wire        y_a;

  // Instance B: N=3 W=2 GAP=0 DWELL=3
  logic       rst_b, mode_b, vld_b, rdy_b, err_b, yvld_b;
  logic [1:0] sel_b, csel_b, yq_b;
  logic [5:0] i_b;
  logic [2:0] en_b;
  wire  [1:0] y_b;

  tri_bus_sel #(.N(4), .W(1), .GAP(1), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .mode(mode_a), .req_vld(vld_a), .req_sel(sel_a),
    .req_rdy(rdy_a), .i(i_a), .en(en_a), .y(y_a), .cur_sel(csel_a),
    .y_q(yq_a), .y_vld(yvld_a), .err(err_a)
  );

  tri_bus_sel #(.N(3), .W(2), .GAP(0), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_b), .mode(mode_b), .req_vld(vld_b), .req_sel(sel_b),
    .req_rdy(rdy_b), .i(i_b), .en(en_b), .y(y_b), .cur_sel(csel_b),
    .y_q(yq_b), .y_vld(yvld_b), .err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst, mode, vld;
    logic [1:0] sel;
    logic [3:0] en;
    logic [1:0] csel;
    logic       yv, yq, rdy, y;
  } vec_t;

  vec_t vec[$];

  task automatic add(input logic r, m, v, input logic [1:0] s, input logic [3:0] e,
                     input logic [1:0] cs, input logic yv, yq, rdy, y);
    vec_t t;
    t.rst = r; t.mode = m; t.vld = v; t.sel = s; t.en = e; t.csel = cs;
    t.yv = yv; t.yq = yq; t.rdy = rdy; t.y = y;
    vec.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic stepb(input logic r, input logic v, input logic [1:0] s);
    @(negedge clk);
    rst_b = r; vld_b = v; sel_b = s;
    @(posedge clk);
    #1;
  endtask

  // No two drivers may ever be on together.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(en_a) || !$onehot0(en_b)) begin
      errors++;
      $display("FAIL onehot0 en_a=%b en_b=%b", en_a, en_b);
    end
  end

  initial begin
    rst_a = 0; mode_a = 0; vld_a = 0; sel_a = 0; i_a = 4'b1010;
    rst_b = 0; mode_b = 0; vld_b = 0; sel_b = 0; i_b = 6'b11_10_01;

    //   r m v sel   en      cs  yv yq rdy y
    add(0,0,0,0, 4'b0000, 0, 0, 0, 0, 0); // in reset
    add(1,0,0,0, 4'b0000, 0, 0, 0, 1, 0); // idle after reset
    add(1,0,1,1, 4'b0000, 1, 0, 0, 0, 0); // accept ch1 -> gap
    add(1,0,0,0, 4'b0010, 1, 0, 0, 1, 1); // drive ch1
    add(1,0,0,0, 4'b0010, 1, 1, 1, 1, 1); // capture valid
    add(1,0,1,1, 4'b0010, 1, 1, 1, 1, 1); // same sel: no change
    add(1,0,1,2, 4'b0000, 2, 0, 1, 0, 0); // switch 1->2: break
    add(1,0,0,0, 4'b0100, 2, 0, 1, 1, 0); // make ch2
    add(1,0,0,0, 4'b0100, 2, 1, 0, 1, 0);
    add(1,1,0,0, 4'b0100, 2, 1, 0, 0, 0); // manual->scan, dwell restarts
    add(1,1,0,0, 4'b0100, 2, 1, 0, 0, 0);
    add(1,1,0,0, 4'b0000, 3, 0, 0, 0, 0); // dwell done -> ch3
    add(1,1,0,0, 4'b1000, 3, 0, 0, 0, 1);
    add(1,1,0,0, 4'b1000, 3, 1, 1, 0, 1);
    add(1,1,0,0, 4'b0000, 0, 0, 1, 0, 0); // wrap 3->0
    add(1,1,0,0, 4'b0001, 0, 0, 1, 0, 0);
    add(1,1,0,0, 4'b0001, 0, 1, 0, 0, 0);
    add(1,1,0,0, 4'b0000, 1, 0, 0, 0, 0);
    add(1,1,0,0, 4'b0010, 1, 0, 0, 0, 1);
    add(1,0,0,0, 4'b0010, 1, 1, 1, 0, 1); // scan->manual waits for dwell end
    add(1,0,0,0, 4'b0010, 1, 1, 1, 1, 1); // held on ch1, manual
    add(1,0,0,0, 4'b0010, 1, 1, 1, 1, 1);
    add(0,0,0,0, 4'b0000, 0, 0, 0, 0, 0); // reset mid-drive
    add(1,1,0,0, 4'b0000, 0, 0, 0, 0, 0); // scan from idle
    add(1,1,0,0, 4'b0001, 0, 0, 0, 0, 0);
    add(1,1,0,0, 4'b0001, 0, 1, 0, 0, 0);
    add(1,1,0,0, 4'b0000, 1, 0, 0, 0, 0);

    for (int k = 0; k < vec.size(); k++) begin
      @(negedge clk);
      rst_a = vec[k].rst; mode_a = vec[k].mode; vld_a = vec[k].vld; sel_a = vec[k].sel;
      @(posedge clk);
      #1;
      chk($sformatf("a%0d en", k),      32'(en_a),   32'(vec[k].en));
      chk($sformatf("a%0d cur_sel", k), 32'(csel_a), 32'(vec[k].csel));
      chk($sformatf("a%0d y_vld", k),   32'(yvld_a), 32'(vec[k].yv));
      chk($sformatf("a%0d y_q", k),     32'(yq_a),   32'(vec[k].yq));
      chk($sformatf("a%0d req_rdy", k), 32'(rdy_a),  32'(vec[k].rdy));
      chk($sformatf("a%0d err", k),     32'(err_a),  32'(1'b0));
      if (vec[k].en != 4'b0000)
        chk($sformatf("a%0d y", k),     32'(y_a),    32'(vec[k].y));
    end

    stepb(0, 0, 0);
    chk("b reset en", 32'(en_b), 32'(0));
    chk("b reset y_vld", 32'(yvld_b), 32'(0));
    stepb(1, 1, 3); // illegal from idle
    chk("b idle err", 32'(err_b), 32'(1));
    chk("b idle en", 32'(en_b), 32'(0));
    chk("b idle rdy", 32'(rdy_b), 32'(1));
    stepb(1, 1, 0); // no gap: enable on at accept edge
    chk("b ch0 en", 32'(en_b), 32'(3'b001));
    chk("b ch0 err", 32'(err_b), 32'(0));
    chk("b ch0 y", 32'(y_b), 32'(2'b01));
    stepb(1, 0, 0);
    chk("b ch0 y_vld", 32'(yvld_b), 32'(1));
    chk("b ch0 y_q", 32'(yq_b), 32'(2'b01));
    stepb(1, 1, 1); // direct 001 -> 010
    chk("b ch1 en", 32'(en_b), 32'(3'b010));
    chk("b ch1 cur_sel", 32'(csel_b), 32'(1));
    chk("b ch1 y_vld", 32'(yvld_b), 32'(0));
    chk("b ch1 y", 32'(y_b), 32'(2'b10));
    stepb(1, 0, 0);
    chk("b ch1 y_q", 32'(yq_b), 32'(2'b10));
    stepb(1, 1, 3); // illegal while driving
    chk("b drv err", 32'(err_b), 32'(1));
    chk("b drv en", 32'(en_b), 32'(3'b010));
    chk("b drv cur_sel", 32'(csel_b), 32'(1));
    stepb(1, 0, 0);
    chk("b err pulse", 32'(err_b), 32'(0));
    chk("b hold en", 32'(en_b), 32'(3'b010));
    stepb(1, 1, 2);
    chk("b ch2 en", 32'(en_b), 32'(3'b100));
    chk("b ch2 y", 32'(y_b), 32'(2'b11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
